axi_fifo_rr_arbiter: RTL and testbench
======================================

// Module: axi_fifo_rr_arbiter
// PURPOSE
// - Shares one AXI-stream FIFO input between NUM_PORTS packet sources using round-robin arbitration.
// - Grants whole packets, delimited by tlast, so packets are never interleaved.
// - Starts a new packet only when the downstream FIFO reports space >= MIN_SPACE.
// - Sits directly in front of the axi_fifo family and drives its i_* side; fifo_space comes from that FIFO's space output.
// PARAMETERS
// - WIDTH      32   data width per port, in bits
// - NUM_PORTS  4    number of requesters, 2..8
// - MIN_SPACE  16   minimum FIFO free entries needed to grant a new packet (max packet length)
// PORTS
// - clk         in   1               single clock domain
// - reset_n     in   1               asynchronous, active-low reset
// - clear       in   1               synchronous flush, active-high
// - i_tdata     in   NUM_PORTS*WIDTH port p occupies bits [p*WIDTH +: WIDTH]
// - i_tlast     in   NUM_PORTS       end-of-packet flag, one per port
// - i_tvalid    in   NUM_PORTS       valid, one per port
// - i_tready    out  NUM_PORTS       ready, one per port; only the granted bit can be 1
// - o_tdata     out  WIDTH           to FIFO i_tdata
// - o_tlast     out  1               to FIFO (side-band or widened data)
// - o_tvalid    out  1               to FIFO i_tvalid
// - o_tready    in   1               from FIFO i_tready
// - fifo_space  in   18              FIFO free entries
// - grant       out  NUM_PORTS       one-hot active grant, for status
// - busy        out  1               high in PASS state, or while the output register holds data
// BEHAVIOUR
// - Reset values, while reset_n is low: state=IDLE, rr_ptr=0, grant=0, i_tready=0, o_tvalid=0, o_tdata=0, o_tlast=0, busy=0.
// - States are IDLE and PASS.
// - IDLE -> PASS transition:
//   - Condition: |i_tvalid && fifo_space >= MIN_SPACE.
//   - grant is registered to the first valid port found searching upward from rr_ptr, with wrap-around.
//   - No data moves in IDLE.
// - PASS handshake:
//   - i_tready[g] = skid input ready; all other i_tready bits are 0.
//   - A beat is accepted when i_tvalid[g] && i_tready[g].
// - PASS -> IDLE transition:
//   - Taken on acceptance of a beat with i_tlast[g]=1.
//   - rr_ptr = (g+1) mod NUM_PORTS; grant is cleared.
// - Result: one bubble cycle between packets. Sustained throughput inside a packet is 1 beat/clk.
// - Output register is a 2-entry skid buffer:
//   - Latency from i-accept to o_tvalid is 1 clk.
//   - o_tready deassertion never drops or duplicates a beat.
//   - i_tready never depends combinationally on o_tready.
// - fifo_space is sampled only at grant time; it is ignored during PASS.
//   - MIN_SPACE must cover the worst packet length plus 2 skid entries.
// - A grant is held until tlast, even if i_tvalid[g] drops mid-packet (gaps allowed).
// - Simultaneous requests: the lowest index at or above rr_ptr wins.
//   - A requester that just finished cannot win the next grant while any other port is valid.
// - A tlast beat accepted in the same cycle that a new request arrives: the new request is granted in the next IDLE cycle.
// - clear:
//   - Same effect as reset on the next edge; overrides all other activity.
//   - Mid-packet clear truncates the packet; the downstream FIFO sees no tlast. Upstream must also clear.
// - Port index widths are $clog2(NUM_PORTS). NUM_PORTS values that are not powers of 2 wrap explicitly at NUM_PORTS-1.
// STRUCTURE
// - Shared header axi_fifo_arb_defs.vh:
//   - state encodings ST_IDLE=1'b0, ST_PASS=1'b1
//   - MAX_PORTS=8
// - Sub-module axi_skid_reg #(WIDTH+1): the 2-entry output register carrying {tlast,tdata}.
// - Top level contains the FSM, the round-robin search and the input mux.
// TESTING
// 1. Ports 0..3 each send one 4-beat packet at the same time, fifo_space=128.
//    - Required: output order P0,P1,P2,P3; tlast on every 4th beat; exactly one idle cycle between packets.
// 2. Port 1 streams back-to-back packets while port 2 sends one packet.
//    - Required: grants alternate 1,2,1; port 1 never receives two consecutive grants while port 2 is valid.
// 3. fifo_space=8 < MIN_SPACE=16 with port 0 valid.
//    - Required: no grant and i_tready=0.
//    - Set fifo_space=16: grant goes to port 0 on the next clk and data flows.
// 4. Mid-packet, o_tready toggles randomly at 50% with i_tvalid held high.
//    - Required: output beat sequence is identical to input, with no loss or duplication; throughput is 1/clk whenever o_tready=1.
// 5. Mid-packet, port 2 deasserts i_tvalid for 3 cycles while port 0 is valid.
//    - Required: grant stays on port 2 and port 0 is stalled until port 2's tlast.
// 6. reset_n pulsed low for 1 cycle mid-packet, then clear pulsed high for 1 cycle on a later packet.
//    - Required: o_tvalid=0 and grant=0 immediately on reset and after clear; rr_ptr=0; the next grant goes to the lowest valid port.

Source files
------------

// File: rtl/axi_fifo_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_fifo_rr_arbiter_pkg
// Description : Shared definitions for the round-robin packet arbiter that
//               feeds the axi_fifo family: FSM state encodings, the port-count
//               ceiling and a wrap-around port increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_fifo_rr_arbiter_pkg;

    // FSM encodings (single bit: the arbiter is either idle or passing a packet)
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_PASS = 1'b1;

    // Largest supported requester count
    localparam int c_MAX_PORTS = 8;

    // Next port index after idx, wrapping explicitly at num_ports-1 so that
    // non-power-of-two port counts never land on a nonexistent port.
    function automatic int unsigned next_port(input int unsigned idx,
                                              input int unsigned num_ports);
        return (idx + 32'd1 >= num_ports) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : axi_skid_reg
// Description : Two-entry valid/ready output register (skid buffer). One beat
//               of latency from input accept to o_valid; o_ready is a pure
//               register output so the upstream ready never depends
//               combinationally on the downstream i_ready.
// Revision    : 1.0 - initial release
// Ports       :
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   clear    in   synchronous flush, active-high
//   i_data   in   WIDTH  upstream payload
//   i_valid  in   upstream valid
//   o_ready  out  upstream ready (low only while the skid entry is occupied)
//   o_data   out  WIDTH  downstream payload
//   o_valid  out  downstream valid
//   i_ready  in   downstream ready
//   o_busy   out  at least one entry holds data
// ============================================================================
module axi_skid_reg #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    logic             w_in_fire;
    logic             w_out_free;

    // The skid entry only fills when the output is stalled, so an empty skid
    // entry guarantees room for one more beat regardless of i_ready.
    assign o_ready    = ~r_skid_valid;
    assign w_in_fire  = i_valid & ~r_skid_valid;
    assign w_out_free = ~r_out_valid | i_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (clear) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_out_free) begin
            // Output slot is moving: refill from skid first (older beat),
            // otherwise from the input, otherwise go empty.
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_out_data  <= i_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            // Output stalled: park the incoming beat in the skid entry.
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
        end
    end

    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;
    assign o_busy  = r_out_valid | r_skid_valid;

endmodule
`default_nettype wire

// File: rtl/axi_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_fifo_rr_arbiter
// Description : Round-robin packet arbiter sharing one AXI-stream FIFO input
//               between NUM_PORTS sources. Whole packets (delimited by tlast)
//               are granted; a new packet starts only when the downstream FIFO
//               reports at least MIN_SPACE free entries.
// Revision    : 1.0 - initial release
// Ports       :
//   clk         in   clock
//   reset_n     in   asynchronous active-low reset
//   clear       in   synchronous flush, active-high
//   i_tdata     in   NUM_PORTS*WIDTH  port p at [p*WIDTH +: WIDTH]
//   i_tlast     in   NUM_PORTS        end-of-packet per port
//   i_tvalid    in   NUM_PORTS        valid per port
//   i_tready    out  NUM_PORTS        ready per port (granted bit only)
//   o_tdata     out  WIDTH            to FIFO data
//   o_tlast     out  end-of-packet to FIFO
//   o_tvalid    out  valid to FIFO
//   o_tready    in   ready from FIFO
//   fifo_space  in   18               FIFO free entries
//   grant       out  NUM_PORTS        one-hot active grant
//   busy        out  passing a packet or output register non-empty
// ============================================================================
module axi_fifo_rr_arbiter
    import axi_fifo_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_PORTS = 4,   // 2..c_MAX_PORTS
    parameter int MIN_SPACE = 16   // worst packet length plus 2 skid entries
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic [NUM_PORTS*WIDTH-1:0] i_tdata,
    input  logic [NUM_PORTS-1:0]       i_tlast,
    input  logic [NUM_PORTS-1:0]       i_tvalid,
    output logic [NUM_PORTS-1:0]       i_tready,
    output logic [WIDTH-1:0]           o_tdata,
    output logic                       o_tlast,
    output logic                       o_tvalid,
    input  logic                       o_tready,
    input  logic [17:0]                fifo_space,
    output logic [NUM_PORTS-1:0]       grant,
    output logic                       busy
);

    localparam int c_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Registered state
    logic [0:0]           r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_gnt_idx;
    logic [NUM_PORTS-1:0] r_grant;

    // Combinational
    logic [0:0]           w_state_next;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_sel_idx;
    logic [c_IDX_W:0]     w_cand;
    logic [NUM_PORTS-1:0] w_sel_onehot;
    logic                 w_space_ok;
    logic [WIDTH-1:0]     w_sel_tdata;
    logic                 w_sel_tlast;
    logic                 w_sel_tvalid;
    logic                 w_skid_in_valid;
    logic                 w_skid_in_ready;
    logic                 w_skid_busy;
    logic                 w_accept;

    assign w_space_ok   = (fifo_space >= 18'(MIN_SPACE));
    assign w_sel_onehot = NUM_PORTS'(1) << w_sel_idx;

    // ------------------------------------------------------------------
    // Round-robin search: first valid port at or above r_rr_ptr, wrapping.
    // The candidate is one bit wider so the wrap can be done by a single
    // conditional subtract, which also covers non-power-of-two counts.
    // ------------------------------------------------------------------
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
            if (w_cand >= (c_IDX_W+1)'(NUM_PORTS)) begin
                w_cand = w_cand - (c_IDX_W+1)'(NUM_PORTS);
            end
            if (!w_found && i_tvalid[w_cand[c_IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_sel_idx = w_cand[c_IDX_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Input mux for the granted port
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_tdata  = '0;
        w_sel_tlast  = 1'b0;
        w_sel_tvalid = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_gnt_idx == c_IDX_W'(p)) begin
                w_sel_tdata  = i_tdata[p*WIDTH +: WIDTH];
                w_sel_tlast  = i_tlast[p];
                w_sel_tvalid = i_tvalid[p];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else if (clear) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // fifo_space matters only here, at grant time; during PASS it is ignored.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_found && w_space_ok)     w_state_next = c_ST_PASS;
            c_ST_PASS: if (w_accept && w_sel_tlast)   w_state_next = c_ST_IDLE;
            default:                                  w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Only the granted port sees the skid ready; the grant is
    // held through valid gaps until its tlast beat is accepted.
    // ------------------------------------------------------------------
    always_comb begin
        w_skid_in_valid = 1'b0;
        i_tready        = '0;
        if (r_state == c_ST_PASS) begin
            w_skid_in_valid = w_sel_tvalid;
            i_tready        = r_grant & {NUM_PORTS{w_skid_in_ready}};
        end
    end

    assign w_accept = w_skid_in_valid & w_skid_in_ready;

    // ------------------------------------------------------------------
    // Grant and round-robin pointer. After a packet the pointer moves past
    // the finishing port so it cannot win again while another port waits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_grant   <= '0;
        end else if (clear) begin
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_grant   <= '0;
        end else if (r_state == c_ST_IDLE && w_state_next == c_ST_PASS) begin
            r_gnt_idx <= w_sel_idx;
            r_grant   <= w_sel_onehot;
        end else if (r_state == c_ST_PASS && w_state_next == c_ST_IDLE) begin
            r_rr_ptr  <= c_IDX_W'(next_port(32'(r_gnt_idx), NUM_PORTS));
            r_grant   <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Output register carrying {tlast, tdata}
    // ------------------------------------------------------------------
    axi_skid_reg #(
        .WIDTH (WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .i_data  ({w_sel_tlast, w_sel_tdata}),
        .i_valid (w_skid_in_valid),
        .o_ready (w_skid_in_ready),
        .o_data  ({o_tlast, o_tdata}),
        .o_valid (o_tvalid),
        .i_ready (o_tready),
        .o_busy  (w_skid_busy)
    );

    assign grant = r_grant;
    assign busy  = (r_state == c_ST_PASS) | w_skid_busy;

endmodule
`default_nettype wire

// File: tb/tb_axi_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_fifo_rr_arbiter
// Description : Self-checking bench for axi_fifo_rr_arbiter. Sources are
//               per-port packet queues; a packet-level reference model picks
//               the winner, tracks output-register occupancy and pushes every
//               accepted beat into a scoreboard that an independent monitor
//               drains on each downstream handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_fifo_rr_arbiter;

    localparam int WIDTH     = 32;
    localparam int N         = 4;
    localparam int MIN_SPACE = 16;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear;
    logic [N*WIDTH-1:0] i_tdata;
    logic [N-1:0]     i_tlast;
    logic [N-1:0]     i_tvalid;
    logic [N-1:0]     i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;
    logic [17:0]      fifo_space;
    logic [N-1:0]     grant;
    logic             busy;

    always #5 clk = ~clk;

    axi_fifo_rr_arbiter #(
        .WIDTH     (WIDTH),
        .NUM_PORTS (N),
        .MIN_SPACE (MIN_SPACE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .i_tdata    (i_tdata),
        .i_tlast    (i_tlast),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .fifo_space (fifo_space),
        .grant      (grant),
        .busy       (busy)
    );

    // Stimulus sources and knobs
    beat_t        src_q [N][$];
    int           gap_pct;
    logic [N-1:0] gap_force;
    bit           rdy_mode;      // 0: o_tready=1, 1: random 50%
    bit           clear_req;
    logic [17:0]  space_cfg;

    // Reference model
    bit    m_pass;
    int    m_g;
    int    m_ptr;
    int    m_occ;               // beats held in the 2-entry output register
    beat_t exp_q [$];

    // Grant history (start of each grant)
    int           gnt_log [$];
    logic [N-1:0] prev_grant;

    int n_vec;
    int n_err;

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.last = (i == len - 1);
            b.data = $urandom;
            src_q[p].push_back(b);
        end
    endtask

    task automatic flush_sources();
        for (int p = 0; p < N; p++) src_q[p].delete();
    endtask

    task automatic model_flush();
        m_pass = 1'b0;
        m_g    = 0;
        m_ptr  = 0;
        m_occ  = 0;
        exp_q.delete();
    endtask

    // Advance the model across the coming clock edge, given the driven inputs.
    task automatic model_step();
        bit    out_fire;
        bit    acc;
        bit    found;
        beat_t b;
        out_fire = (m_occ > 0) && o_tready;
        acc      = 1'b0;
        if (clear) begin
            model_flush();
            return;
        end
        if (m_pass) begin
            if (i_tvalid[m_g] && m_occ < 2) begin
                acc = 1'b1;
                b   = src_q[m_g].pop_front();
                exp_q.push_back(b);
                if (b.last) begin
                    m_pass = 1'b0;
                    m_ptr  = (m_g + 1) % N;
                end
            end
        end else if (i_tvalid != '0 && space_cfg >= 18'(MIN_SPACE)) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && i_tvalid[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    m_g   = (m_ptr + k) % N;
                end
            end
            m_pass = 1'b1;
        end
        m_occ = m_occ - int'(out_fire) + int'(acc);
    endtask

    task automatic check_outputs();
        check("grant",    64'(grant),    64'(m_pass ? onehot(m_g) : '0));
        check("i_tready", 64'(i_tready), 64'((m_pass && m_occ < 2) ? onehot(m_g) : '0));
        check("o_tvalid", 64'(o_tvalid), 64'(m_occ > 0));
        check("busy",     64'(busy),     64'(m_pass || m_occ > 0));
        if (grant != '0 && prev_grant == '0) gnt_log.push_back(int'(grant));
        prev_grant = grant;
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < N; p++) begin
            if (src_q[p].size() > 0) begin
                i_tdata[p*WIDTH +: WIDTH] = src_q[p][0].data;
                i_tlast[p]  = src_q[p][0].last;
                i_tvalid[p] = !gap_force[p] && ($urandom_range(99) >= gap_pct);
            end else begin
                i_tdata[p*WIDTH +: WIDTH] = $urandom;
                i_tlast[p]  = 1'b0;
                i_tvalid[p] = 1'b0;
            end
        end
        clear      = clear_req;
        fifo_space = space_cfg;
        o_tready   = clear_req ? 1'b0 : (rdy_mode ? 1'($urandom_range(1)) : 1'b1);
    endtask

    // One clock: check state left by the last edge, drive, predict next edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        check_outputs();
        drive_inputs();
        if (!reset_n) model_flush();
        else          model_step();
    endtask

    function automatic bit model_idle();
        bit e;
        e = !m_pass && m_occ == 0 && exp_q.size() == 0;
        for (int p = 0; p < N; p++) if (src_q[p].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic run_until_idle(input int budget, input string name);
        int i;
        i = 0;
        while (!model_idle() && i < budget) begin
            cycle();
            i++;
        end
        n_vec++;
        if (!model_idle()) begin
            n_err++;
            $display("FAIL %s: drain timeout after %0d cycles, %0d beats outstanding", name, i, exp_q.size());
        end
    endtask

    task automatic wait_grant(input logic [N-1:0] exp, input string name);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (grant != '0) break;
        end
        check(name, 64'(grant), 64'(exp));
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        model_flush();
        flush_sources();
        #1;
        check("rst_o_tvalid", 64'(o_tvalid), 64'(0));
        check("rst_grant",    64'(grant),    64'(0));
        check("rst_i_tready", 64'(i_tready), 64'(0));
        cycle();
        // Sources are empty, so no model step is owed for the release edge.
        reset_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each downstream handshake.
    beat_t mb;
    always @(negedge clk) begin
        if (reset_n && o_tvalid && o_tready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_unexpected: got beat %0h, expected none", {o_tlast, o_tdata});
            end else begin
                mb = exp_q.pop_front();
                check("out_beat", 64'({o_tlast, o_tdata}), 64'(mb));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        reset_n = 1'b0; clear = 1'b0; clear_req = 1'b0;
        gap_force = '0; gap_pct = 0; rdy_mode = 1'b0; space_cfg = 18'd128;
        i_tdata = '0; i_tlast = '0; i_tvalid = '0; o_tready = 1'b1; fifo_space = 18'd128;
        prev_grant = '0;
        model_flush();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_tvalid", 64'(o_tvalid), 64'(0));
        check("reset_o_tdata",  64'(o_tdata),  64'(0));
        check("reset_o_tlast",  64'(o_tlast),  64'(0));
        check("reset_grant",    64'(grant),    64'(0));
        check("reset_i_tready", 64'(i_tready), 64'(0));
        check("reset_busy",     64'(busy),     64'(0));
        reset_n = 1'b1;

        // 1: four simultaneous 4-beat packets
        gnt_log.delete();
        for (int p = 0; p < N; p++) add_pkt(p, 4);
        run_until_idle(200, "t1_drain");
        check("t1_order_n", 64'(gnt_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) check("t1_order", 64'(gnt_log[i]), 64'(onehot(i)));

        // 2: port 1 back-to-back packets against a single port 2 packet
        gnt_log.delete();
        for (int i = 0; i < 3; i++) add_pkt(1, 3);
        add_pkt(2, 5);
        run_until_idle(200, "t2_drain");
        check("t2_g0", 64'(gnt_log[0]), 64'(4'b0010));
        check("t2_g1", 64'(gnt_log[1]), 64'(4'b0100));
        check("t2_g2", 64'(gnt_log[2]), 64'(4'b0010));

        // 3: insufficient FIFO space blocks the grant
        space_cfg = 18'd8;
        add_pkt(0, 4);
        repeat (5) cycle();
        check("t3_nogrant",  64'(grant),    64'(0));
        check("t3_noready",  64'(i_tready), 64'(0));
        space_cfg = 18'd16;
        cycle();
        cycle();
        check("t3_grant", 64'(grant), 64'(4'b0001));
        run_until_idle(200, "t3_drain");
        space_cfg = 18'd128;

        // 4: random downstream backpressure
        rdy_mode = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < N; p++) add_pkt(p, $urandom_range(14, 1));
        run_until_idle(2000, "t4_drain");
        rdy_mode = 1'b0;

        // 5: valid gap on the granted port while another port waits
        add_pkt(2, 8);
        cycle();
        add_pkt(0, 4);
        repeat (3) cycle();
        gap_force[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_hold_grant", 64'(grant),       64'(4'b0100));
            check("t5_p0_stall",   64'(i_tready[0]), 64'(0));
        end
        gap_force = '0;
        run_until_idle(200, "t5_drain");

        // 6a: reset mid-packet with a non-zero round-robin pointer
        add_pkt(1, 3);
        run_until_idle(200, "t6_pre");
        add_pkt(2, 10);
        repeat (4) cycle();
        pulse_reset();
        add_pkt(1, 3);
        add_pkt(3, 3);
        wait_grant(4'b0010, "t6_rst_lowest");
        run_until_idle(200, "t6_post_rst");

        // 6b: clear mid-packet
        add_pkt(3, 10);
        repeat (4) cycle();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        flush_sources();
        cycle();
        check("t6_clr_o_tvalid", 64'(o_tvalid), 64'(0));
        check("t6_clr_grant",    64'(grant),    64'(0));
        add_pkt(0, 2);
        add_pkt(3, 2);
        wait_grant(4'b0001, "t6_clr_ptr0");
        run_until_idle(200, "t6_post_clr");

        // Random soak
        gap_pct  = 30;
        rdy_mode = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(5) == 0) begin
                int p;
                p = $urandom_range(N - 1);
                if (src_q[p].size() < 40) add_pkt(p, $urandom_range(14, 1));
            end
            space_cfg = 18'($urandom_range(40, 8));
            cycle();
        end
        gap_pct   = 0;
        rdy_mode  = 1'b0;
        space_cfg = 18'd128;
        run_until_idle(3000, "soak_drain");

        repeat (2) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
